// File: rtl/rps_defs.sv
// Definitions shared by the rock-paper-scissors winner logic and the match controller:
// throw encodings, result codes, controller state encoding and a one-hot legality helper.
package rps_defs;

   localparam logic [2:0] ROCK     = 3'b100;
   localparam logic [2:0] PAPER    = 3'b010;
   localparam logic [2:0] SCISSORS = 3'b001;

   localparam logic [1:0] RES_A   = 2'b10;
   localparam logic [1:0] RES_B   = 2'b01;
   localparam logic [1:0] RES_TIE = 2'b00;

   typedef enum logic [1:0] {
      PLAY = 2'd0,
      HOLD = 2'd1,
      DONE = 2'd2
   } match_state_e;

   // A throw is legal only if it is exactly one of the three encodings.
   function automatic logic is_one_hot3(input logic [2:0] t);
      return (t == ROCK) || (t == PAPER) || (t == SCISSORS);
   endfunction

endpackage

// File: rtl/rps_hold_timer.sv
// Post-round hold down-counter: load starts a countdown, clr aborts it,
// done is high whenever the count has reached zero.
module rps_hold_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/rps_match_ctrl.sv
// Match controller: accepts decided rounds, checks throw legality, keeps win/tie tallies,
// enforces a hold period between rounds and declares the match at WINS_TO_MATCH wins.
module rps_match_ctrl
   import rps_defs::*;
#(
   parameter int WINS_TO_MATCH = 3,
   parameter int CNT_W         = 3,
   parameter int TIE_W         = 4,
   parameter int HOLD_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       throw_a,
   input  logic [2:0]       throw_b,
   input  logic [2:0]       score,
   input  logic             round_valid,
   input  logic             new_match,
   output logic             round_ready,
   output logic [CNT_W-1:0] a_wins,
   output logic [CNT_W-1:0] b_wins,
   output logic [TIE_W-1:0] ties,
   output logic [1:0]       last_result,
   output logic             illegal_throw,
   output logic             match_over,
   output logic [1:0]       match_winner
);

   localparam int               TMR_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WIN_LIM   = CNT_W'(WINS_TO_MATCH);
   localparam logic [TIE_W-1:0] TIE_MAX   = '1;

   match_state_e     state, state_nxt;
   logic             legal;
   logic [CNT_W-1:0] a_inc, b_inc;
   logic             inc_a, inc_b, inc_tie, bad_round;
   logic             timer_load, timer_done;
   logic             unused_score;

   // score[2] carries nothing for this block.
   assign unused_score = score[2];

   assign legal = is_one_hot3(throw_a) && is_one_hot3(throw_b) && (score[1:0] != 2'b11);
   assign a_inc = a_wins + 1'b1;
   assign b_inc = b_wins + 1'b1;

   rps_hold_timer #(
      .W (TMR_W)
   ) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (new_match),
      .load     (timer_load),
      .load_val (HOLD_LOAD),
      .done     (timer_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= PLAY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      inc_a      = 1'b0;
      inc_b      = 1'b0;
      inc_tie    = 1'b0;
      bad_round  = 1'b0;
      timer_load = 1'b0;
      // new_match outranks any round strobed in the same cycle.
      if (new_match) begin
         state_nxt = PLAY;
      end else begin
         case (state)
            PLAY: begin
               if (round_valid) begin
                  if (!legal) begin
                     bad_round = 1'b1;
                  end else begin
                     inc_a   = score[1];
                     inc_b   = score[0];
                     inc_tie = ~|score[1:0];
                     if ((score[1] && (a_inc == WIN_LIM)) || (score[0] && (b_inc == WIN_LIM))) begin
                        state_nxt = DONE;
                     end else begin
                        state_nxt  = HOLD;
                        timer_load = 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if (timer_done) begin
                  state_nxt = PLAY;
               end
            end
            DONE: begin
               state_nxt = DONE;
            end
            default: begin
               state_nxt = PLAY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || new_match) begin
         a_wins        <= '0;
         b_wins        <= '0;
         ties          <= '0;
         last_result   <= RES_TIE;
         match_winner  <= 2'b00;
         illegal_throw <= 1'b0;
      end else begin
         illegal_throw <= bad_round;
         if (inc_a) begin
            a_wins <= a_inc;
         end
         if (inc_b) begin
            b_wins <= b_inc;
         end
         if (inc_tie && (ties != TIE_MAX)) begin
            ties <= ties + 1'b1;
         end
         if (inc_a || inc_b || inc_tie) begin
            last_result <= score[1:0];
         end
         if ((state_nxt == DONE) && (state != DONE)) begin
            match_winner <= inc_a ? RES_A : RES_B;
         end
      end
   end

   // Status outputs are registered copies of the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         round_ready <= 1'b1;
         match_over  <= 1'b0;
      end else begin
         round_ready <= (state_nxt == PLAY);
         match_over  <= (state_nxt == DONE);
      end
   end

endmodule
